// File: rtl/ballot_collector_if.sv
// Vote channel between a vote source and the ballot collector.
// Valid/ready handshake carrying one voter ID and its yes/no value per transfer.
interface ballot_collector_if #(
    parameter int IDW = 3
) ();
    logic           vote_valid;
    logic [IDW-1:0] vote_id;
    logic           vote_val;
    logic           vote_ready;

    modport master (
        output vote_valid,
        output vote_id,
        output vote_val,
        input  vote_ready
    );

    modport slave (
        input  vote_valid,
        input  vote_id,
        input  vote_val,
        output vote_ready
    );
endinterface

// File: rtl/ballot_collector.sv
// Sequential front end for the majority voter: collects one vote per voter over a
// valid/ready channel and presents the assembled vote vector with a one-cycle strobe.
module ballot_collector #(
    parameter int N_VOTERS = 7,
    parameter int TIMEOUT  = 255,
    parameter int IDW      = $clog2(N_VOTERS),
    parameter int CW       = $clog2(N_VOTERS + 1)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    ballot_collector_if.slave   vote_if,
    output logic [N_VOTERS-1:0] votes,
    output logic                votes_valid,
    output logic [CW-1:0]       count,
    output logic                timed_out,
    output logic                dup_err,
    output logic                id_err,
    output logic                busy
);

    localparam int TW = $clog2(TIMEOUT + 1);

    localparam logic [IDW:0]  ID_LIMIT   = (IDW + 1)'(N_VOTERS);
    localparam logic [CW-1:0] LAST_COUNT = CW'(N_VOTERS - 1);
    localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        DONE    = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [N_VOTERS-1:0] votes_q, votes_d;
    logic [N_VOTERS-1:0] voted_q, voted_d;
    logic [CW-1:0]       count_q, count_d;
    logic [TW-1:0]       timer_q, timer_d;
    logic                timed_out_q, timed_out_d;
    logic                dup_err_q, dup_err_d;
    logic                id_err_q, id_err_d;

    logic [N_VOTERS-1:0] id_onehot;
    logic                id_bad;
    logic                id_seen;
    logic                accept_new;

    // Out-of-range IDs shift the one-hot to zero, so they can never touch the vectors.
    assign id_onehot  = {{(N_VOTERS-1){1'b0}}, 1'b1} << vote_if.vote_id;
    assign id_bad     = {1'b0, vote_if.vote_id} >= ID_LIMIT;
    assign id_seen    = |(voted_q & id_onehot);
    assign accept_new = (state_q == COLLECT) && vote_if.vote_valid && !id_bad && !id_seen;

    always_comb begin
        // NOTE: every variable gets its hold value first so no path can infer a latch.
        state_d     = state_q;
        votes_d     = votes_q;
        voted_d     = voted_q;
        count_d     = count_q;
        timer_d     = timer_q;
        timed_out_d = timed_out_q;
        dup_err_d   = 1'b0;
        id_err_d    = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d     = COLLECT;
                    votes_d     = '0;
                    voted_d     = '0;
                    count_d     = '0;
                    timer_d     = '0;
                    timed_out_d = 1'b0;
                end
            end

            COLLECT: begin
                if (vote_if.vote_valid) begin
                    id_err_d  = id_bad;
                    dup_err_d = !id_bad && id_seen;
                end
                if (accept_new) begin
                    votes_d = vote_if.vote_val ? (votes_q | id_onehot) : (votes_q & ~id_onehot);
                    voted_d = voted_q | id_onehot;
                    count_d = count_q + CW'(1);
                    timer_d = '0;
                    // A completing vote also clears the timer, so it beats a same-edge timeout.
                    if (count_q == LAST_COUNT) state_d = DONE;
                end else begin
                    timer_d = timer_q + TW'(1);
                    if (timer_q == TIMER_LAST) begin
                        state_d     = DONE;
                        timed_out_d = 1'b1;
                    end
                end
            end

            DONE: state_d = IDLE;

            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (rst) begin
            state_q     <= IDLE;
            votes_q     <= '0;
            voted_q     <= '0;
            count_q     <= '0;
            timer_q     <= '0;
            timed_out_q <= 1'b0;
            dup_err_q   <= 1'b0;
            id_err_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            votes_q     <= votes_d;
            voted_q     <= voted_d;
            count_q     <= count_d;
            timer_q     <= timer_d;
            timed_out_q <= timed_out_d;
            dup_err_q   <= dup_err_d;
            id_err_q    <= id_err_d;
        end
    end

    assign vote_if.vote_ready = (state_q == COLLECT);
    assign votes_valid        = (state_q == DONE);
    assign busy               = (state_q != IDLE);
    assign votes              = votes_q;
    assign count              = count_q;
    assign timed_out          = timed_out_q;
    assign dup_err            = dup_err_q;
    assign id_err             = id_err_q;

endmodule
